aes_spi_loader: RTL and testbench

- SPI-facing front end that sits directly upstream of the AES round controller.
- Shifts in plaintext and key from the MCU and pulses the controller's load input.
- Waits for the controller's completion flag, then captures the cyphertext and shifts it back out to the MCU.
- Single clk domain; the SPI pins are synchronized and edge-detected internally.

---
 rtl/aes_spi_pkg.sv | 18 +
 rtl/aes_spi_loader_if.sv | 30 +++
 rtl/spi_sync_edge.sv | 30 +++
 rtl/aes_spi_loader.sv | 161 ++++++++++++++++
 tb/tb_aes_spi_loader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_spi_pkg.sv
// Shared types and sizing constants for the AES SPI loader.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    LAUNCH,
    BUSY,
    READY,
    SEND
  } spi_state_t;

  localparam int unsigned BLOCK_W_DEF   = 128;
  localparam int unsigned FRAME_FULL    = 256;
  localparam int unsigned FRAME_PT_ONLY = 128;
  localparam int unsigned CNT_W         = 9;

endpackage

// File: rtl/aes_spi_loader_if.sv
// Loader <-> AES round controller bus: load strobe, operand blocks, completion and result.
interface aes_spi_loader_if
  import aes_spi_pkg::*;
#(
  parameter int unsigned BLOCK_W = BLOCK_W_DEF
);

  logic               load;
  logic [BLOCK_W-1:0] plaintext;
  logic [BLOCK_W-1:0] key;
  logic               cipher_complete;
  logic [BLOCK_W-1:0] cyphertext;

  modport master (
    output load,
    output plaintext,
    output key,
    input  cipher_complete,
    input  cyphertext
  );

  modport slave (
    input  load,
    input  plaintext,
    input  key,
    output cipher_complete,
    output cyphertext
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async pin, plus rise/fall pulses from one extra history flop.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/aes_spi_loader.sv
// SPI front end for the AES round controller: receives pt/key frames, launches, returns cyphertext.
// Optional build macro AES_SPI_KEY_RETAIN_EN accepts BLOCK_W-bit frames that reuse the held key.
module aes_spi_loader
  import aes_spi_pkg::*;
#(
  parameter int unsigned BLOCK_W     = BLOCK_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  input  logic             ce,
  output logic             sdo,
  output logic             done,
  output logic             busy,
  output logic             frame_err,
  aes_spi_loader_if.master ctl
);

  localparam int unsigned FRAME_W = 2 * BLOCK_W;

  logic sck_rise_c, sck_fall_c, ce_rise_c, ce_fall_c, sdi_s;
  logic sck_level_unused, ce_level_unused, sdi_rise_unused, sdi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .reset(reset), .din(sck),
    .level(sck_level_unused), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ce_sync (
    .clk(clk), .reset(reset), .din(ce),
    .level(ce_level_unused), .rise_c(ce_rise_c), .fall_c(ce_fall_c)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi_sync (
    .clk(clk), .reset(reset), .din(sdi),
    .level(sdi_s), .rise_c(sdi_rise_unused), .fall_c(sdi_fall_unused)
  );

  spi_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] in_sr_q, in_sr_d;
  logic [BLOCK_W-1:0] out_sr_q, out_sr_d;
  logic [BLOCK_W-1:0] pt_q, pt_d, key_q, key_d;
  logic               frame_err_q, frame_err_d;
  logic               load_q, load_d, busy_q, busy_d, done_q, done_d, sdo_q, sdo_d;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_sr_q     <= '0;
      out_sr_q    <= '0;
      pt_q        <= '0;
      key_q       <= '0;
      frame_err_q <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sdo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_sr_q     <= in_sr_d;
      out_sr_q    <= out_sr_d;
      pt_q        <= pt_d;
      key_q       <= key_d;
      frame_err_q <= frame_err_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sdo_q       <= sdo_d;
    end
  end

  // Next-state and datapath; a ce fall takes priority over any sck edge in the same cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_sr_d     = in_sr_q;
    out_sr_d    = out_sr_q;
    pt_d        = pt_q;
    key_d       = key_q;
    frame_err_d = frame_err_q;

    case (state_q)
      IDLE: begin
        if (ce_rise_c) begin
          state_d = RECV;
          cnt_d   = '0;
          in_sr_d = '0;
        end
      end
      RECV: begin
        if (ce_fall_c) begin
          if (cnt_q == CNT_W'(FRAME_W)) begin
            pt_d        = in_sr_q[FRAME_W-1:BLOCK_W];
            key_d       = in_sr_q[BLOCK_W-1:0];
            frame_err_d = 1'b0;
            state_d     = LAUNCH;
          end
`ifdef AES_SPI_KEY_RETAIN_EN
          else if (cnt_q == CNT_W'(BLOCK_W)) begin
            pt_d        = in_sr_q[BLOCK_W-1:0];
            frame_err_d = 1'b0;
            state_d     = LAUNCH;
          end
`endif
          else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (sck_rise_c && (cnt_q != CNT_W'(FRAME_W))) begin
          in_sr_d = {in_sr_q[FRAME_W-2:0], sdi_s};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      LAUNCH: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (ctl.cipher_complete) begin
          out_sr_d = ctl.cyphertext;
          state_d  = READY;
        end
      end
      READY: begin
        if (ce_rise_c) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (ce_fall_c) begin
          out_sr_d = '0;
          state_d  = IDLE;
        end else if (sck_fall_c) begin
          out_sr_d = {out_sr_q[BLOCK_W-2:0], 1'b0};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    load_d = (state_q == LAUNCH);
    busy_d = (state_d == LAUNCH) || (state_d == BUSY);
    done_d = (state_d == READY) || (state_d == SEND);
    sdo_d  = done_d & out_sr_d[BLOCK_W-1];
  end

  assign sdo           = sdo_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign frame_err     = frame_err_q;
  assign ctl.load      = load_q;
  assign ctl.plaintext = pt_q;
  assign ctl.key       = key_q;

endmodule

// File: tb/tb_aes_spi_loader.sv
// Directed bench for aes_spi_loader with a round-controller model on the ctl bus.
module tb_aes_spi_loader;
  import aes_spi_pkg::*;

  localparam int unsigned BW = 128;
  localparam logic [BW-1:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BW-1:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BW-1:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [BW-1:0] PT2  = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [BW-1:0] KEY2 = 128'h0f0e0d0c0b0a09080706050403020100;

  logic clk, reset, sck, sdi, ce, sdo, done, busy, frame_err;
  aes_spi_loader_if #(.BLOCK_W(BW)) ctl ();

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;
  int lat      = 20;
  int cc_timer = 0;
  logic [BW-1:0] cur_pt, cur_key;

  aes_spi_loader #(.BLOCK_W(BW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ce(ce),
    .sdo(sdo), .done(done), .busy(busy), .frame_err(frame_err), .ctl(ctl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [BW-1:0] model_ct(input logic [BW-1:0] p, input logic [BW-1:0] k);
    return ((p == PT) && (k == KEY)) ? CT : (p ^ k);
  endfunction

  // Round-controller model: completion level rises lat cycles after a load
  initial begin
    ctl.cipher_complete = 1'b0;
    ctl.cyphertext      = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cc_timer            = 0;
        ctl.cipher_complete = 1'b0;
      end else if (ctl.load) begin
        load_cnt++;
        ctl.cipher_complete = 1'b0;
        cc_timer            = lat;
        cur_pt              = ctl.plaintext;
        cur_key             = ctl.key;
      end else if (cc_timer > 0) begin
        cc_timer--;
        if (cc_timer == 0) begin
          ctl.cyphertext      = model_ct(cur_pt, cur_key);
          ctl.cipher_complete = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input logic [511:0] data, input int n, input bit drop_ce);
    ce = 1'b1;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = data[i];
      tick(5);
      sck = 1'b1;
      tick(5);
      sck = 1'b0;
    end
    sdi = 1'b0;
    tick(5);
    if (drop_ce) ce = 1'b0;
  endtask

  task automatic read_block(output logic [BW-1:0] d);
    ce = 1'b1;
    tick(5);
    for (int i = BW - 1; i >= 0; i--) begin
      d[i] = sdo;
      sck  = 1'b1;
      tick(5);
      sck  = 1'b0;
      tick(5);
    end
    check("sdo_drained", sdo, 0);
    ce = 1'b0;
    tick(6);
    check("done_clear", done, 0);
    check("sdo_idle", sdo, 0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && (k < budget)) begin
      tick(1);
      k++;
    end
    check("done_wait", done, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sdo"}, sdo, 0);
    check({tag, "_load"}, ctl.load, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_pt"}, ctl.plaintext, 0);
    check({tag, "_key"}, ctl.key, 0);
  endtask

  task automatic full_run(input logic [BW-1:0] p, input logic [BW-1:0] k, input logic [BW-1:0] exp_ct);
    logic [BW-1:0] rd;
    int lc;
    lc = load_cnt;
    spi_frame(512'({p, k}), 256, 1'b1);
    tick(10);
    check("run_load", load_cnt, lc + 1);
    check("run_pt", ctl.plaintext, p);
    check("run_key", ctl.key, k);
    wait_done(100);
    read_block(rd);
    check("run_ct", rd, exp_ct);
  endtask

  initial begin
    logic [BW-1:0] rd;
    int lc;
    reset = 1'b0; sck = 1'b0; sdi = 1'b0; ce = 1'b0;
    tick(3);
    check_reset_vals("rst");
    reset = 1'b1;
    tick(3);

    // Nominal encryption with exact load latency
    lc = load_cnt;
    spi_frame(512'({PT, KEY}), 256, 1'b1);
    tick(3);
    check("load_early", ctl.load, 0);
    tick(1);
    check("load_lat", ctl.load, 1);
    check("busy_launch", busy, 1);
    check("nom_pt", ctl.plaintext, PT);
    check("nom_key", ctl.key, KEY);
    tick(1);
    check("load_width", ctl.load, 0);
    tick(5);
    check("nom_load_cnt", load_cnt, lc + 1);
    wait_done(100);
    check("busy_cleared", busy, 0);
    check("ready_sdo_msb", sdo, CT[BW-1]);
    read_block(rd);
    check("nom_ct", rd, CT);

    // Cipher_complete is still high here in IDLE and must not set done
    tick(10);
    check("spurious_cc", done, 0);

    // Short frame
    lc = load_cnt;
    spi_frame(512'({PT2, KEY2}) >> 1, 255, 1'b1);
    tick(10);
    check("short_ferr", frame_err, 1);
    check("short_load", load_cnt, lc);
    check("short_pt", ctl.plaintext, PT);
    check("short_key", ctl.key, KEY);
    full_run(PT2, KEY2, PT2 ^ KEY2);
    check("ferr_cleared", frame_err, 0);

    // Overlong frame: trailing 44 bits ignored
    lc = load_cnt;
    spi_frame(512'({PT, KEY, 44'hfffffffffff}), 300, 1'b1);
    tick(10);
    check("long_load", load_cnt, lc + 1);
    check("long_pt", ctl.plaintext, PT);
    check("long_key", ctl.key, KEY);
    wait_done(100);
    read_block(rd);
    check("long_ct", rd, CT);

    // SPI activity during BUSY is ignored
    lat = 300;
    lc  = load_cnt;
    spi_frame(512'({PT2, KEY2}), 256, 1'b1);
    tick(6);
    check("bsy_busy", busy, 1);
    spi_frame(512'(16'ha5a5), 16, 1'b1);
    tick(10);
    check("bsy_pt", ctl.plaintext, PT2);
    check("bsy_key", ctl.key, KEY2);
    check("bsy_ferr", frame_err, 0);
    check("bsy_still", busy, 1);
    check("bsy_nodone", done, 0);
    check("bsy_load", load_cnt, lc + 1);
    wait_done(400);
    read_block(rd);
    check("bsy_ct", rd, PT2 ^ KEY2);

    // Reset mid-RECV after 100 bits
    lat = 20;
    lc  = load_cnt;
    spi_frame(512'({PT, KEY}) >> 156, 100, 1'b0);
    reset = 1'b0;
    tick(2);
    check_reset_vals("rstrx");
    ce = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(20);
    check("rstrx_load", load_cnt, lc);
    check("rstrx_done", done, 0);

    // Reset mid-BUSY
    lat = 300;
    spi_frame(512'({PT2, KEY2}), 256, 1'b1);
    tick(20);
    check("rstbsy_busy", busy, 1);
    lc = load_cnt;
    reset = 1'b0;
    tick(2);
    check_reset_vals("rstbsy");
    reset = 1'b1;
    tick(50);
    check("rstbsy_load", load_cnt, lc);
    check("rstbsy_done", done, 0);
    check("rstbsy_idle", busy, 0);

    // Retain-key frame after a nominal run
    lat = 20;
    full_run(PT, KEY, CT);
    lc = load_cnt;
    spi_frame(512'(PT), 128, 1'b1);
    tick(10);
`ifdef AES_SPI_KEY_RETAIN_EN
    check("ret_load", load_cnt, lc + 1);
    check("ret_ferr", frame_err, 0);
    check("ret_pt", ctl.plaintext, PT);
    check("ret_key", ctl.key, KEY);
    wait_done(100);
    read_block(rd);
    check("ret_ct", rd, CT);
`else
    check("ret_ferr", frame_err, 1);
    check("ret_load", load_cnt, lc);
    check("ret_pt", ctl.plaintext, PT);
    check("ret_key", ctl.key, KEY);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
